// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity codes.
// Used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity of a zero-extended data word for the given mode.
  function automatic logic parity_bit(
    input logic [8:0] word,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1.
// Synchronous clear holds the count at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST) && !clr;

  // Free-running bit-period counter, wraps after the last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with one-entry holding register.
// Configurable data width, parity and stop bits.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Tx_DV_in,
  input  logic [DATA_BITS-1:0] Tx_Byte_in,
  output logic                 Tx_Ready_out,
  output logic                 Tx_Active_out,
  output logic                 Tx_Serial_out,
  output logic                 Tx_Done_out
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 2047 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_framed: parameter out of range");
  end

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  uart_state_t          state, state_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic                 stop_q, stop_n;
  logic [DATA_BITS-1:0] hold_q, shift_q, shift_n;
  logic                 hold_full, accept, load;
  logic                 tick, serial_q, serial_n, done;

  assign accept        = Tx_DV_in && !hold_full;
  assign Tx_Ready_out  = !hold_full;
  assign Tx_Active_out = (state != S_IDLE);
  assign Tx_Serial_out = serial_q;
  assign Tx_Done_out   = done;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (CLK),
    .rst (RST),
    .clr (state == S_IDLE),
    .tick(tick)
  );

  // Holding register: capture when empty, release on shifter load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_q    <= Tx_Byte_in;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame sequencing and next line level.
  always_comb begin
    state_n  = state;
    bit_n    = bit_q;
    stop_n   = stop_q;
    load     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            bit_n   = '0;
            stop_n  = 1'b0;
            state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_n = S_STOP;
          stop_n  = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            done   = 1'b1;
            stop_n = 1'b0;
            if (hold_full) begin
              load    = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    shift_n  = load ? hold_q : shift_q;
    serial_n = 1'b1;
    unique case (1'b1)
      (state_n == S_START):  serial_n = 1'b0;
      (state_n == S_DATA):   serial_n = shift_n[bit_n];
      (state_n == S_PARITY): serial_n = parity_bit(9'(shift_n), PARITY);
      default:               serial_n = 1'b1;
    endcase
  end

  // State, counters, shifter and registered line output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state    <= state_n;
      bit_q    <= bit_n;
      stop_q   <= stop_n;
      shift_q  <= shift_n;
      serial_q <= serial_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed in four configurations:
// 8N1/4, 7E2/4, 7O1/4 and 9N1/2 clocks per bit.
module tb_uart_tx_framed;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  n;
    logic        gap;
    logic        abrt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v [4];
  logic       dv    [4];
  logic [8:0] dat   [4];
  logic       rdy   [4];
  logic       act   [4];
  logic       ser   [4];
  logic       done_v[4];

  int tests = 0;
  int fails = 0;

  exp_t expq [4][$];
  exp_t cur  [4];
  bit   busy [4];
  bit   err  [4];
  int   pos  [4];
  int   since[4];
  int   cpb  [4] = '{4, 4, 4, 2};

  always #5 clk = ~clk;

  uart_tx_framed #(
    .CLKS_PER_BIT(4), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .CLK(clk), .RST(rst_v[0]),
    .Tx_DV_in(dv[0]), .Tx_Byte_in(dat[0][7:0]),
    .Tx_Ready_out(rdy[0]), .Tx_Active_out(act[0]),
    .Tx_Serial_out(ser[0]), .Tx_Done_out(done_v[0])
  );

  uart_tx_framed #(
    .CLKS_PER_BIT(4), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2)
  ) u1 (
    .CLK(clk), .RST(rst_v[1]),
    .Tx_DV_in(dv[1]), .Tx_Byte_in(dat[1][6:0]),
    .Tx_Ready_out(rdy[1]), .Tx_Active_out(act[1]),
    .Tx_Serial_out(ser[1]), .Tx_Done_out(done_v[1])
  );

  uart_tx_framed #(
    .CLKS_PER_BIT(4), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1)
  ) u2 (
    .CLK(clk), .RST(rst_v[2]),
    .Tx_DV_in(dv[2]), .Tx_Byte_in(dat[2][6:0]),
    .Tx_Ready_out(rdy[2]), .Tx_Active_out(act[2]),
    .Tx_Serial_out(ser[2]), .Tx_Done_out(done_v[2])
  );

  uart_tx_framed #(
    .CLKS_PER_BIT(2), .DATA_BITS(9),
    .PARITY(0), .STOP_BITS(1)
  ) u3 (
    .CLK(clk), .RST(rst_v[3]),
    .Tx_DV_in(dv[3]), .Tx_Byte_in(dat[3]),
    .Tx_Ready_out(rdy[3]), .Tx_Active_out(act[3]),
    .Tx_Serial_out(ser[3]), .Tx_Done_out(done_v[3])
  );

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Expected frame: bits[k] is the line level of frame bit k.
  task automatic push(input int i, input logic [15:0] b,
                      input int n, input bit g, input bit a);
    exp_t e;
    e.bits = b;
    e.n    = 5'(n);
    e.gap  = g;
    e.abrt = a;
    expq[i].push_back(e);
  endtask

  task automatic send(input int i, input logic [8:0] d);
    int k;
    @(negedge clk);
    k = 0;
    while (!rdy[i] && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!rdy[i]) begin
      fails++;
      $display("FAIL send_timeout dut%0d ready got 0 want 1", i);
    end
    dv[i]  = 1'b1;
    dat[i] = d;
    @(negedge clk);
    dv[i]  = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 600; k++) begin
      if (expq[i].size() == 0 && !busy[i]) break;
      @(negedge clk);
    end
    if (expq[i].size() != 0 || busy[i]) begin
      fails++;
      $display("FAIL idle_timeout dut%0d pending %0d want 0",
               i, expq[i].size());
    end
    repeat (4) @(negedge clk);
    chk($sformatf("idle_line dut%0d", i),
        {13'd0, ser[i], rdy[i], act[i]}, 16'h0006);
  endtask

  // Monitor: decode every frame on each line against the queue.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_v[i]) begin
        if (busy[i]) begin
          tests++;
          if (!cur[i].abrt || err[i]) begin
            fails++;
            $display("FAIL abort dut%0d got reset want frame end", i);
          end
          busy[i] = 1'b0;
        end
        since[i] = 1;
      end else begin
        if (!busy[i] && ser[i] == 1'b0) begin
          busy[i] = 1'b1;
          pos[i]  = 0;
          err[i]  = 1'b0;
          if (expq[i].size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame dut%0d got start want idle", i);
            cur[i] = '{bits: 16'h0, n: 5'd10, gap: 1'b0, abrt: 1'b1};
          end else begin
            cur[i] = expq[i].pop_front();
            if (cur[i].gap && since[i] != 0) begin
              fails++;
              $display("FAIL gap dut%0d got %0d idle cycles want 0",
                       i, since[i]);
            end
          end
        end
        if (busy[i]) begin
          int b, tot;
          b   = pos[i] / cpb[i];
          tot = int'(cur[i].n) * cpb[i];
          if (ser[i] !== cur[i].bits[b] || act[i] !== 1'b1 ||
              done_v[i] !== (pos[i] == tot - 1))
            err[i] = 1'b1;
          if (pos[i] == tot - 1) begin
            tests++;
            if (err[i]) begin
              fails++;
              $display("FAIL frame dut%0d got bad level/done want %h",
                       i, cur[i].bits);
            end
            busy[i]  = 1'b0;
            since[i] = 0;
          end else begin
            pos[i]++;
          end
        end else begin
          if (done_v[i] || act[i]) begin
            fails++;
            $display("FAIL idle_outputs dut%0d done %b act %b want 0 0",
                     i, done_v[i], act[i]);
          end
          since[i]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1;
      dv[i]    = 1'b0;
      dat[i]   = '0;
      busy[i]  = 1'b0;
      err[i]   = 1'b0;
      pos[i]   = 0;
      since[i] = 1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset dut%0d ser/rdy/act/done", i),
          {12'd0, ser[i], rdy[i], act[i], done_v[i]}, 16'h000C);
    #1;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;

    // 8N1 0xA5 with two-cycle latency from acceptance.
    push(0, 16'h034A, 10, 1'b0, 1'b0);
    send(0, 9'h0A5);
    chk("latency_pre ser/rdy", {14'd0, ser[0], rdy[0]}, 16'h0002);
    @(negedge clk);
    chk("latency_start ser/act", {14'd0, ser[0], act[0]}, 16'h0001);
    wait_idle(0);

    // 7E2 and 7O1 with word 0x41.
    push(1, 16'h0682, 11, 1'b0, 1'b0);
    send(1, 9'h041);
    wait_idle(1);
    push(2, 16'h0382, 10, 1'b0, 1'b0);
    send(2, 9'h041);
    wait_idle(2);

    // 9 data bits at two clocks per bit, back to back.
    push(3, 16'h07FE, 11, 1'b0, 1'b0);
    push(3, 16'h0554, 11, 1'b1, 1'b0);
    send(3, 9'h1FF);
    send(3, 9'h0AA);
    wait_idle(3);

    // Back-to-back 0x55, 0x0F; then valid held while full.
    push(0, 16'h02AA, 10, 1'b0, 1'b0);
    push(0, 16'h021E, 10, 1'b1, 1'b0);
    send(0, 9'h055);
    chk("ready_after_accept1", {15'd0, rdy[0]}, 16'h0000);
    repeat (8) @(negedge clk);
    send(0, 9'h00F);
    chk("ready_after_accept2", {15'd0, rdy[0]}, 16'h0000);
    dv[0]  = 1'b1;
    dat[0] = 9'h0FF;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy[0]) cnt++;
    end
    dv[0] = 1'b0;
    chk("ready_while_full_cycles", 16'(cnt), 16'h0000);
    wait_idle(0);

    // Reset during data bit 3 of 0x33.
    push(0, 16'h0266, 10, 1'b0, 1'b1);
    send(0, 9'h033);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("pre_reset_bit3", {15'd0, ser[0]}, 16'h0000);
    #2;
    rst_v[0] = 1'b1;
    #1;
    chk("mid_reset ser/rdy/act/done",
        {12'd0, ser[0], rdy[0], act[0], done_v[0]}, 16'h000C);
    @(negedge clk);
    #1;
    rst_v[0] = 1'b0;
    push(0, 16'h034A, 10, 1'b0, 1'b0);
    send(0, 9'h0A5);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
